// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared CPU front-end types and constants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } fetch_state_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with flush; wrap-bit pointers give full/empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
    import cpu_pkg::*;
#(
    parameter int WIDTH = 2 * XLEN,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    // Flush wins over a same-cycle push so nothing stale survives a redirect.
    assign w_push = push & ~full & ~flush;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= wdata;
    end

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;
    assign rdata = empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Purpose  : Sequential instruction fetch with one outstanding request, a
//            small instruction queue and redirect flush. Optional counters
//            enabled by defining FETCHQ_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
`ifdef FETCHQ_STATS_EN
    ,
    output logic [31:0]     stat_fetched,
    output logic [31:0]     stat_flushed,
    output logic [31:0]     stat_full_cyc
`endif
);

    localparam int c_AW = $clog2(DEPTH);

    fetch_state_t       r_state;
    logic [XLEN-1:0]    r_fetch_pc;
    logic               r_req;

    logic               w_pop;
    logic               w_push;
    logic               w_full;
    logic               w_empty;
    logic [c_AW:0]      w_count;
    logic [c_AW+1:0]    w_count_after;
    logic               w_room;
    logic               w_outstanding;
    logic [XLEN-1:0]    w_target;
    logic [XLEN+ILEN-1:0] w_head;

    assign w_pop         = inst_valid & inst_ready;
    assign w_push        = (r_state == WAIT) & imem_ack & ~redirect & ~w_full;
    assign w_outstanding = (r_state == WAIT) || (r_state == DRAIN);
    assign w_target      = {redirect_pc[XLEN-1:2], 2'b00};

    // Occupancy after this cycle's push, net of a same-cycle pop.
    assign w_count_after = {1'b0, w_count} + (c_AW+2)'(1) - (c_AW+2)'(w_pop);
    assign w_room        = w_count_after < (c_AW+2)'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req      <= 1'b0;
        end else if (redirect) begin
            r_fetch_pc <= w_target;
            // A request already in flight must have its ack swallowed first.
            if (w_outstanding && !imem_ack) begin
                r_state <= DRAIN;
                r_req   <= 1'b0;
            end else begin
                r_state <= REQ;
                r_req   <= 1'b1;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= REQ;
                    r_req   <= 1'b1;
                end
                REQ: begin
                    r_state <= WAIT;
                    r_req   <= 1'b0;
                end
                WAIT: begin
                    if (imem_ack) begin
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                        if (w_room) begin
                            r_state <= REQ;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_pop) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // A redirect in REQ cancels that cycle's request so no stale ack follows.
    assign imem_req  = r_req & ~redirect;
    assign imem_addr = r_fetch_pc;

    sync_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect),
        .wdata ({r_fetch_pc, imem_rdata}),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign inst_valid = ~w_empty;
    assign inst_pc    = w_head[XLEN+ILEN-1:ILEN];
    assign inst       = w_head[ILEN-1:0];

`ifdef FETCHQ_STATS_EN
    logic [31:0]     r_stat_fetched;
    logic [31:0]     r_stat_flushed;
    logic [31:0]     r_stat_full_cyc;
    logic [c_AW+1:0] w_flush_entries;
    logic            w_discard;

    // Entries still queued after an honoured pop are the ones lost.
    assign w_flush_entries = redirect ? ({1'b0, w_count} - (c_AW+2)'(w_pop)) : '0;
    assign w_discard       = imem_ack & ((r_state == DRAIN) | ((r_state == WAIT) & redirect));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_fetched  <= '0;
            r_stat_flushed  <= '0;
            r_stat_full_cyc <= '0;
        end else begin
            r_stat_fetched  <= sat_add32(r_stat_fetched, 32'(w_push));
            r_stat_flushed  <= sat_add32(r_stat_flushed,
                                         32'(w_flush_entries) + 32'(w_discard));
            r_stat_full_cyc <= sat_add32(r_stat_full_cyc, 32'(r_state == HOLD));
        end
    end

    assign stat_fetched  = r_stat_fetched;
    assign stat_flushed  = r_stat_flushed;
    assign stat_full_cyc = r_stat_full_cyc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue: memory responder, program-
//            order scoreboard and directed plus random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;
    import cpu_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCHQ_STATS_EN
    logic [31:0] stat_fetched, stat_flushed, stat_full_cyc;
`endif

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
`ifdef FETCHQ_STATS_EN
        ,
        .stat_fetched  (stat_fetched),
        .stat_flushed  (stat_flushed),
        .stat_full_cyc (stat_full_cyc)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory responder state
    bit          outstanding = 1'b0;
    int          lat_cnt = 0;
    int          lat_fix = 0;
    logic [31:0] req_addr = '0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;
    int          req_count = 0;
    logic [31:0] last_req_addr = '0;
    bit          req_last = 1'b0;

    // Scoreboard state: expected program-order PCs
    logic [31:0] exp_q[$];
    bit          want_first = 1'b0;
    logic [31:0] want_addr = '0;
    bit          flush_chk = 1'b0;
    int          pops = 0;
    logic [31:0] prev_pop_pc = '0;
    bit          saw_wrap = 1'b0;
    bit          pop_on_redirect = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (outstanding) begin
            lat_cnt--;
            if (lat_cnt <= 0) begin
                imem_ack    = 1'b1;
                imem_rdata  = ovr_en ? ovr_data : word_at(req_addr);
                outstanding = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        req_last = (imem_req === 1'b1);
        if (imem_req === 1'b1) begin
            chk("one_outstanding", 32'(outstanding), 32'd0);
            outstanding   = 1'b1;
            lat_cnt       = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
            req_addr      = imem_addr;
            last_req_addr = imem_addr;
            req_count++;
            if (want_first) begin
                chk("first_req_addr", imem_addr, want_addr);
                want_first = 1'b0;
            end
        end
        if (rst) begin
            exp_q.delete();
            exp_q.push_back(RPC);
            want_first = 1'b1;
            want_addr  = RPC;
            flush_chk  = 1'b0;
            continue;
        end
        if (flush_chk) begin
            chk("flush_empty", 32'(inst_valid), 32'd0);
            flush_chk = 1'b0;
        end
        if (inst_valid && inst_ready) begin
            logic [31:0] pc;
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                pc = exp_q.pop_front();
                chk("inst_pc", inst_pc, pc);
                chk("inst", inst, word_at(pc));
                exp_q.push_back(pc + 32'd4);
                if (pc == 32'd0 && prev_pop_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
                prev_pop_pc = pc;
                pops++;
            end
            if (redirect && imem_ack) pop_on_redirect = 1'b1;
        end
        if (redirect) begin
            exp_q.delete();
            exp_q.push_back({redirect_pc[31:2], 2'b00});
            flush_chk  = 1'b1;
            want_first = 1'b1;
            want_addr  = {redirect_pc[31:2], 2'b00};
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Hold reset until any in-flight ack has been delivered.
    task automatic do_reset(input int n);
        rst      = 1'b1;
        redirect = 1'b0;
        cyc(n);
        for (int i = 0; i < 10 && outstanding; i++) cyc(1);
        rst = 1'b0;
    endtask

    task automatic wait_wait_state(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            cyc(1);
            if (req_last) found = 1'b1;
        end
        if (!found) chk(name, 32'd0, 32'd1);
    endtask

    initial begin
        int r0, p0;
        bit found;
        bit last_redir;

        @(posedge clk);
        #2;
        @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, RPC);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);

        // Streaming with one-cycle memory latency
        lat_fix = 1; inst_ready = 1'b1;
        do_reset(3);
        cyc(10);
        r0 = req_count;
        cyc(20);
        chk("t1_req_rate", 32'(req_count - r0), 32'd10);

        // Backpressure fills the queue, then drains
        lat_fix = 0; inst_ready = 1'b0;
        do_reset(3);
        r0 = req_count;
        cyc(20);
        chk("t2_pushes", 32'(req_count - r0), 32'(DEPTH));
        @(negedge clk);
        chk("t2_hold_req", 32'(imem_req), 32'd0);
        chk("t2_full_valid", 32'(inst_valid), 32'd1);
        p0 = pops;
        @(posedge clk); #2;
        inst_ready = 1'b1;
        cyc(4);
        chk("t2_drain_count", 32'(pops - p0), 32'd4);
        for (int i = 0; i < 50 && (req_count - r0) < DEPTH + 1; i++) cyc(1);
        chk("t2_resume_addr", last_req_addr, 32'h10);

        // Redirect while waiting; the stale word must be dropped
        lat_fix = 3; inst_ready = 1'b1;
        do_reset(3);
        cyc(6);
        wait_wait_state("t3_find_wait");
        ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        cyc(1);
        redirect = 1'b0;
        cyc(2);
        ovr_en = 1'b0;
        p0 = pops;
        cyc(20);
        chk("t3_progress", 32'(pops > p0), 32'd1);

        // Redirect coincident with ack and pop
        lat_fix = 0; inst_ready = 1'b0;
        do_reset(3);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc(1);
            if (imem_ack && inst_valid) found = 1'b1;
        end
        chk("t4_found_ack", 32'(found), 32'd1);
        pop_on_redirect = 1'b0;
        inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        cyc(1);
        redirect = 1'b0;
        chk("t4_pop_with_redirect", 32'(pop_on_redirect), 32'd1);
        cyc(20);

        // PC wrap-around
        do_reset(3);
        cyc(5);
        saw_wrap = 1'b0;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cyc(1);
        redirect = 1'b0;
        cyc(30);
        chk("t5_wrap", 32'(saw_wrap), 32'd1);

        // Reset while a request is outstanding
        lat_fix = 3; inst_ready = 1'b1;
        do_reset(3);
        cyc(3);
        wait_wait_state("t6_find_wait");
        do_reset(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_valid_after_rst", 32'(inst_valid), 32'd0);
        end
        p0 = pops;
        cyc(20);
        chk("t6_progress", 32'(pops > p0), 32'd1);

        // Randomized traffic
        lat_fix = 0;
        do_reset(3);
        p0 = pops;
        last_redir = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            if (!last_redir && $urandom_range(0, 39) == 0) begin
                redirect    = 1'b1;
                redirect_pc = ($urandom_range(0, 3) == 0) ?
                              (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            end else begin
                redirect = 1'b0;
            end
            last_redir = redirect;
            cyc(1);
        end
        redirect = 1'b0;
        cyc(5);
        chk("rand_progress", 32'((pops - p0) > 200), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
